// File: rtl/float_div_nb.sv
// Iterative IEEE 754 single-precision divider (restoring mantissa divide, RNE rounding).
// Define FLOAT_DIV_EXC_EN to build NaN/Inf/zero/overflow/underflow resolution.
module float_div_nb #(
  parameter int ITER_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] din1,
  input  logic [31:0] din2,
  input  logic        din_valid,
  output logic        din_ready,
  output logic [31:0] dout,
  output logic        dout_valid
);

  localparam int         N_CYC = 27 / ITER_PER_CYCLE;
  localparam logic [4:0] LAST  = 5'(N_CYC - 1);

  typedef enum logic [1:0] {IDLE, DIV, RND} state_t;

  state_t             state;
  logic [4:0]         cnt;
  logic               accept;
  logic               sign_r;
  logic               zero_a;
  logic signed [9:0]  exp_r;
  logic [23:0]        mb;
  logic [24:0]        r;
  logic [26:0]        q;
  logic [24:0]        r_nx;
  logic [26:0]        q_nx;
  logic [22:0]        man_pre;
  logic [22:0]        man_rnd;
  logic               g_bit;
  logic               s_bit;
  logic               up;
  logic               carry;
  logic signed [9:0]  e_fin;
  logic [31:0]        result;

  assign accept = din_valid & din_ready;

`ifdef FLOAT_DIV_EXC_EN
  typedef enum logic [1:0] {EXC_NONE, EXC_NAN, EXC_INF, EXC_ZERO} exc_t;

  exc_t exc_in;
  exc_t exc_r;

  always_comb begin
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    a_zero = (din1[30:23] == 8'd0);
    b_zero = (din2[30:23] == 8'd0);
    a_inf  = (&din1[30:23]) & ~(|din1[22:0]);
    b_inf  = (&din2[30:23]) & ~(|din2[22:0]);
    a_nan  = (&din1[30:23]) & (|din1[22:0]);
    b_nan  = (&din2[30:23]) & (|din2[22:0]);
    exc_in = EXC_NONE;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
      exc_in = EXC_NAN;
    else if (b_zero || a_inf)
      exc_in = EXC_INF;
    else if (b_inf)
      exc_in = EXC_ZERO;
  end
`endif

  // One or more restoring-division steps per clock.
  // NOTE: always_comb uses blocking assignments so each unrolled step sees the previous one.
  always_comb begin
    r_nx = r;
    q_nx = q;
    for (int i = 0; i < ITER_PER_CYCLE; i++) begin
      if (r_nx >= {1'b0, mb}) begin
        r_nx = r_nx - {1'b0, mb};
        q_nx = {q_nx[25:0], 1'b1};
      end else begin
        q_nx = {q_nx[25:0], 1'b0};
      end
      r_nx = r_nx << 1;
    end
  end

  always_comb begin
    if (q[26]) begin
      man_pre = q[25:3];
      g_bit   = q[2];
      s_bit   = (|q[1:0]) | (r != 25'd0);
    end else begin
      man_pre = q[24:2];
      g_bit   = q[1];
      s_bit   = q[0] | (r != 25'd0);
    end
    up               = g_bit & (s_bit | man_pre[0]);
    {carry, man_rnd} = {1'b0, man_pre} + {23'd0, up};
    e_fin            = exp_r - (q[26] ? 10'sd0 : 10'sd1) + (carry ? 10'sd1 : 10'sd0);
    result           = {sign_r, e_fin[7:0], man_rnd};
`ifdef FLOAT_DIV_EXC_EN
    if (exc_r == EXC_NAN)
      result = 32'h7FC0_0000;
    else if (exc_r == EXC_INF)
      result = {sign_r, 8'hFF, 23'd0};
    else if (exc_r == EXC_ZERO)
      result = {sign_r, 31'd0};
    else if (zero_a)
      result = 32'd0;
    else if (e_fin >= 10'sd255)
      result = {sign_r, 8'hFF, 23'd0};
    else if (e_fin <= 10'sd0)
      result = {sign_r, 31'd0};
`else
    if (zero_a)
      result = 32'd0;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments; only control and outputs take reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 5'd0;
      din_ready  <= 1'b1;
      dout       <= 32'd0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= DIV;
            cnt       <= 5'd0;
            din_ready <= 1'b0;
          end
        end
        DIV: begin
          if (cnt == LAST)
            state <= RND;
          else
            cnt <= cnt + 5'd1;
        end
        RND: begin
          dout       <= result;
          dout_valid <= 1'b1;
          din_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: datapath registers are always loaded on accept before use, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      sign_r <= din1[31] ^ din2[31];
      zero_a <= (din1[30:23] == 8'd0);
      exp_r  <= $signed({2'b00, din1[30:23]}) - $signed({2'b00, din2[30:23]}) + 10'sd127;
      r      <= {1'b0, din1[30:23] != 8'd0, din1[22:0]};
      mb     <= {din2[30:23] != 8'd0, din2[22:0]};
      q      <= 27'd0;
`ifdef FLOAT_DIV_EXC_EN
      exc_r  <= exc_in;
`endif
    end else if (state == DIV) begin
      r <= r_nx;
      q <= q_nx;
    end
  end

endmodule

// File: tb/tb_float_div_nb.sv
// Randomized self-checking bench for float_div_nb against an integer-arithmetic quotient model.
// Honours FLOAT_DIV_EXC_EN and the ITER_PER_CYCLE parameter.
module tb_float_div_nb #(
  parameter int ITER_PER_CYCLE = 1
);

  localparam int N = 27 / ITER_PER_CYCLE;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] din1 = 32'd0;
  logic [31:0] din2 = 32'd0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [31:0] dout;
  logic        dout_valid;

  float_div_nb #(.ITER_PER_CYCLE(ITER_PER_CYCLE)) dut (
    .clk        (clk),
    .rst        (rst),
    .din1       (din1),
    .din2       (din2),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          acc;
    int          due;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] exp_dout = 32'd0;
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %08h, expected %08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // Quotient as a plain integer division of the scaled mantissas, then RNE.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
    logic   s;
    int     ea, eb, e;
    longint ma, mb, num, qt, rem, man;
    bit     g, st;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
`ifdef FLOAT_DIV_EXC_EN
    begin
      bit a_nan, b_nan, a_inf, b_inf;
      a_nan = (ea == 255) && (a[22:0] != 0);
      b_nan = (eb == 255) && (b[22:0] != 0);
      a_inf = (ea == 255) && (a[22:0] == 0);
      b_inf = (eb == 255) && (b[22:0] == 0);
      if (a_nan || b_nan || (ea == 0 && eb == 0) || (a_inf && b_inf)) return 32'h7FC0_0000;
      if (eb == 0 || a_inf) return {s, 8'hFF, 23'd0};
      if (b_inf) return {s, 31'd0};
    end
`endif
    if (ea == 0) return 32'd0;
    ma  = 64'h80_0000 + longint'(a[22:0]);
    mb  = (eb != 0 ? 64'h80_0000 : 64'd0) + longint'(b[22:0]);
    num = ma << 26;
    qt  = num / mb;
    rem = num % mb;
    e   = ea - eb + 127;
    if (qt >= (64'd1 << 26)) begin
      man = qt >> 3;
      g   = qt[2];
      st  = (qt[1:0] != 0) || (rem != 0);
    end else begin
      man = qt >> 2;
      g   = qt[1];
      st  = qt[0] || (rem != 0);
      e   = e - 1;
    end
    if (g && (st || man[0])) man = man + 1;
    if (man >= (64'd1 << 24)) begin
      man = man >> 1;
      e   = e + 1;
    end
`ifdef FLOAT_DIV_EXC_EN
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0) return {s, 31'd0};
`endif
    return {s, 8'(e), man[22:0]};
  endfunction

  function automatic logic [31:0] rand_op(input bit allow_zero);
    logic [7:0]  e;
    logic [22:0] m;
    e = 8'($urandom_range(180, 70));
    case ($urandom_range(3, 0))
      0:       m = 23'd0;
      1:       m = '1;
      default: m = 23'($urandom);
    endcase
    if (allow_zero && $urandom_range(7, 0) == 0) e = 8'd0;
    return {1'($urandom), e, m};
  endfunction

  // Per-cycle comparison of all outputs against the pending-operation queue.
  always @(negedge clk) begin
    if (!rst) begin
      logic want_valid;
      logic want_ready;
      want_valid = (pend.size() > 0) && (pend[0].due == cyc);
      check("dout_valid", 32'(dout_valid), 32'(want_valid));
      if (want_valid) begin
        exp_dout = pend[0].res;
        void'(pend.pop_front());
      end
      check("dout", dout, exp_dout);
      want_ready = !((pend.size() > 0) && (pend[0].acc <= cyc) && (cyc < pend[0].due));
      check("din_ready", 32'(din_ready), 32'(want_ready));
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the operands.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit noise);
    int budget = 200;
    while (!din_ready) begin
      if (noise) begin
        din1      = $urandom;
        din2      = $urandom;
        din_valid = 1'($urandom);
      end
      @(posedge clk);
      #1;
      budget--;
      if (budget == 0) begin
        timeout("issue");
        return;
      end
    end
    din1      = a;
    din2      = b;
    din_valid = 1'b1;
    pend.push_back('{res: model(a, b), acc: cyc + 1, due: cyc + N + 2});
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int budget = 500;
    while (pend.size() > 0 && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    if (pend.size() > 0) timeout("drain");
  endtask

  initial begin
    int acc;
    int lat;

    // Literal pins on the model itself.
    check("model 6/2", model(32'h40C0_0000, 32'h4000_0000), 32'h4040_0000);
    check("model 1/3", model(32'h3F80_0000, 32'h4040_0000), 32'h3EAA_AAAB);
    check("model 1/1+ulp", model(32'h3F80_0000, 32'h3F80_0001), 32'h3F7F_FFFE);
    check("model -1/0.5", model(32'hBF80_0000, 32'h3F00_0000), 32'hC000_0000);
    check("model 0/5", model(32'h0000_0000, 32'h40A0_0000), 32'h0000_0000);
    check("model -0/5", model(32'h8000_0000, 32'h40A0_0000), 32'h0000_0000);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset dout", dout, 32'd0);
    check("reset dout_valid", 32'(dout_valid), 32'd0);
    check("reset din_ready", 32'(din_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // First op: explicit latency and result.
    issue(32'h40C0_0000, 32'h4000_0000, 1'b0);
    acc       = cyc;
    din_valid = 1'b0;
    lat       = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (dout_valid) begin
        lat = cyc - acc;
        break;
      end
    end
    check("latency edges", 32'(lat), 32'(N + 1));
    check("6/2 dout", dout, 32'h4040_0000);
    @(posedge clk);
    #1;

    // Directed cases, back-to-back with din_valid held high.
    issue(32'h3F80_0000, 32'h4040_0000, 1'b0);
    issue(32'h3F80_0000, 32'h3F80_0001, 1'b0);
    issue(32'hBF80_0000, 32'h3F00_0000, 1'b0);
    issue(32'h0000_0000, 32'h40A0_0000, 1'b0);
    issue(32'h40C0_0000, 32'h4000_0000, 1'b1);
    din_valid = 1'b0;
    drain();

    // Reset ten cycles into an operation.
    issue(32'h3F80_0000, 32'h4040_0000, 1'b0);
    din_valid = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    pend.delete();
    exp_dout = 32'd0;
    @(posedge clk);
    @(negedge clk);
    check("abort dout_valid", 32'(dout_valid), 32'd0);
    check("abort dout", dout, 32'd0);
    check("abort din_ready", 32'(din_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue(32'h40C0_0000, 32'h4000_0000, 1'b0);
    din_valid = 1'b0;
    drain();

`ifdef FLOAT_DIV_EXC_EN
    check("model 1/0", model(32'h3F80_0000, 32'h0000_0000), 32'h7F80_0000);
    check("model ovf", model(32'h7F00_0000, 32'h0080_0000), 32'h7F80_0000);
    check("model 0/0", model(32'h0000_0000, 32'h0000_0000), 32'h7FC0_0000);
    issue(32'h3F80_0000, 32'h0000_0000, 1'b0);
    issue(32'h7F00_0000, 32'h0080_0000, 1'b0);
    issue(32'h0000_0000, 32'h0000_0000, 1'b0);
    issue(32'h7FC0_1234, 32'h3F80_0000, 1'b0);
    issue(32'hFF80_0000, 32'h3F80_0000, 1'b0);
    issue(32'h3F80_0000, 32'hFF80_0000, 1'b0);
    issue(32'h0080_0000, 32'h7F00_0000, 1'b0);
    din_valid = 1'b0;
    drain();
`endif

    // Randomized operations with input noise while busy.
    for (int i = 0; i < 60; i++) begin
      issue(rand_op(1'b1), rand_op(1'b0), 1'b1);
      if ($urandom_range(3, 0) == 0) begin
        din_valid = 1'b0;
        repeat ($urandom_range(4, 1)) begin
          @(posedge clk);
          #1;
        end
      end
    end
    din_valid = 1'b0;
    drain();

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
